// File: rtl/operand_chain_pkg.sv
// Shared definitions for the chained-ALU first-operand selector:
// FSM state encoding and first-operand source codes.
package operand_chain_pkg;

    // Selector FSM: no chain / issued and awaiting result / result held
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHAIN = 2'd2
    } state_t;

    // First-operand source codes carried on src_sel (3 is reserved and behaves as A)
    typedef enum logic [1:0] {
        SRC_A    = 2'd0,
        SRC_LAST = 2'd1,
        SRC_HIST = 2'd2,
        SRC_RSVD = 2'd3
    } src_t;

endpackage

// File: rtl/result_history.sv
// Result history buffer: DEPTH x WIDTH shift register, entry 0 newest.
// The oldest entry falls off when a push arrives with the buffer full.
// flush empties the buffer logically by zeroing the valid count; stale
// data stays in place but is never reported as valid.
module result_history #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int IW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic [IW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] newest,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Shift a new result in at entry 0; older entries move one slot down
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: this buffer is tiny and its reset contents are defined as zero,
        // so it is reset like ordinary flops; a real RAM would be left unreset.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !flush) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
        end
    end

    // Number of valid entries; saturates at DEPTH, flush wins over push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push && (count != CW'(DEPTH))) begin
            count <= count + CW'(1);
        end
    end

    assign rd_data = mem[rd_idx];
    assign newest  = mem[0];

endmodule

// File: rtl/operand_chain_sel.sv
// Registered first-operand selector for the chained ALU datapath.
// First issue of a chain takes operand A; later issues take the last result,
// an older history entry, or A again (which starts a new chain).
// Optional build macro OPERAND_SWAP_EN adds a 'swap' input that exchanges
// opnd_a/opnd_b after source selection.
module operand_chain_sel
    import operand_chain_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNTW  = 4,
    localparam int IW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       src_sel,
    input  logic [IW-1:0]    hist_idx,
`ifdef OPERAND_SWAP_EN
    input  logic             swap,
`endif
    input  logic             op_valid,
    output logic             op_ready,
    output logic [WIDTH-1:0] opnd_a,
    output logic [WIDTH-1:0] opnd_b,
    output logic             opnd_valid,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res,
    output logic             first,
    output logic [CNTW-1:0]  chain_len,
    output logic             sel_err
);

    state_t           state;
    state_t           next_state;
    logic             ready_d;
    logic             first_d;
    logic             accept;
    logic             push;
    logic             flush;
    logic             new_chain;
    logic             sel_miss;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] hist_rd;
    logic [WIDTH-1:0] hist_last;
    logic [CW-1:0]    hist_count;

    // Handshake decode; clear suppresses both issue and result capture
    always_comb begin
        accept = op_valid && !clear && ((state == ST_IDLE) || (state == ST_CHAIN));
        push   = res_valid && !clear && (state == ST_WAIT);
    end

    // First-operand source selection; anything that falls back to A starts a new chain
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        sel_a     = a;
        new_chain = 1'b1;
        sel_miss  = 1'b0;
        if (state == ST_CHAIN) begin
            case (src_t'(src_sel))
                SRC_LAST: begin
                    sel_a     = hist_last;
                    new_chain = 1'b0;
                end
                SRC_HIST: begin
                    if (CW'(hist_idx) < hist_count) begin
                        sel_a     = hist_rd;
                        new_chain = 1'b0;
                    end else begin
                        sel_miss = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign flush = clear || (accept && new_chain);

`ifdef OPERAND_SWAP_EN
    assign out_a = swap ? b : sel_a;
    assign out_b = swap ? sel_a : b;
`else
    assign out_a = sel_a;
    assign out_b = b;
`endif

    // Next-state logic; clear returns to IDLE from any state
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (op_valid)  next_state = ST_WAIT;
                ST_WAIT:  if (res_valid) next_state = ST_CHAIN;
                ST_CHAIN: if (op_valid)  next_state = ST_WAIT;
                default:                 next_state = ST_IDLE;
            endcase
        end
    end

    // Output decode of the upcoming state so op_ready/first come straight from flops
    always_comb begin
        ready_d = (next_state != ST_WAIT);
        first_d = (next_state == ST_IDLE);
    end

    // State register with registered, state-decoded handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state    <= ST_IDLE;
            op_ready <= 1'b1;
            first    <= 1'b1;
        end else begin
            state    <= next_state;
            op_ready <= ready_d;
            first    <= first_d;
        end
    end

    // Operand registers hold until the next accepted issue; pulses last one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd_a     <= '0;
            opnd_b     <= '0;
            opnd_valid <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            opnd_valid <= accept;
            sel_err    <= accept && sel_miss;
            if (accept) begin
                opnd_a <= out_a;
                opnd_b <= out_b;
            end
        end
    end

    // Chain length: restarts with each new chain, saturates at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_len <= '0;
        end else if (flush) begin
            chain_len <= '0;
        end else if (push && (chain_len != {CNTW{1'b1}})) begin
            chain_len <= chain_len + CNTW'(1);
        end
    end

    result_history #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_history (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .din     (res),
        .rd_idx  (hist_idx),
        .rd_data (hist_rd),
        .newest  (hist_last),
        .count   (hist_count)
    );

endmodule

// File: tb/tb_operand_chain_sel.sv
// Self-checking bench for operand_chain_sel (WIDTH=8, DEPTH=4, CNTW=4).
// Expected operand pairs are queued at issue and compared when opnd_valid fires.
module tb_operand_chain_sel;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [1:0] src_sel = '0;
    logic [1:0] hist_idx = '0;
`ifdef OPERAND_SWAP_EN
    logic       swap = 1'b0;
`endif
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [7:0] opnd_a;
    logic [7:0] opnd_b;
    logic       opnd_valid;
    logic       res_valid = 1'b0;
    logic [7:0] res = '0;
    logic       first;
    logic [3:0] chain_len;
    logic       sel_err;

    int    n_vec = 0;
    int    n_bad = 0;
    pair_t sb[$];

    operand_chain_sel #(.WIDTH(8), .DEPTH(4), .CNTW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .a          (a),
        .b          (b),
        .src_sel    (src_sel),
        .hist_idx   (hist_idx),
`ifdef OPERAND_SWAP_EN
        .swap       (swap),
`endif
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .opnd_a     (opnd_a),
        .opnd_b     (opnd_b),
        .opnd_valid (opnd_valid),
        .res_valid  (res_valid),
        .res        (res),
        .first      (first),
        .chain_len  (chain_len),
        .sel_err    (sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] s, input logic [1:0] idx, input logic [7:0] av,
                         input logic [7:0] bv, input logic [7:0] ea, input logic [7:0] eb);
        sb.push_back('{a: ea, b: eb});
        src_sel  = s;
        hist_idx = idx;
        a        = av;
        b        = bv;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic result(input logic [7:0] r);
        res       = r;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    // Scoreboard: every opnd_valid pulse must match the oldest queued pair
    always @(negedge clk) begin
        pair_t e;
        if (!rst && opnd_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_opnd_valid", 32'(opnd_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("opnd_a", 32'(opnd_a), 32'(e.a));
                chk("opnd_b", 32'(opnd_b), 32'(e.b));
            end
        end
    end

    initial begin
        logic [7:0] last;
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_opnd_a", 32'(opnd_a), 32'h00);
        chk("rst_opnd_b", 32'(opnd_b), 32'h00);
        chk("rst_opnd_valid", 32'(opnd_valid), 32'd0);
        chk("rst_op_ready", 32'(op_ready), 32'd1);
        chk("rst_first", 32'(first), 32'd1);
        chk("rst_chain_len", 32'(chain_len), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        rst = 1'b0;
        tick();

        // First issue from IDLE takes A regardless of src_sel; op_valid held into WAIT is ignored
        sb.push_back('{a: 8'h12, b: 8'h03});
        src_sel = 2'd1; a = 8'h12; b = 8'h03; op_valid = 1'b1;
        tick();
        chk("issue_op_ready_low", 32'(op_ready), 32'd0);
        a = 8'hEE;
        tick();
        op_valid = 1'b0;
        chk("opnd_valid_one_cycle", 32'(opnd_valid), 32'd0);
        chk("opnd_a_hold", 32'(opnd_a), 32'h12);

        // Result then chain on last result
        result(8'h15);
        chk("res_op_ready", 32'(op_ready), 32'd1);
        chk("res_chain_len1", 32'(chain_len), 32'd1);
        chk("chain_first_low", 32'(first), 32'd0);
        issue(2'd1, 2'd0, 8'h99, 8'h01, 8'h15, 8'h01);
        result(8'h22);
        chk("chain_len2", 32'(chain_len), 32'd2);

        // src_sel=0 restarts the chain and the history
        issue(2'd0, 2'd0, 8'h77, 8'h02, 8'h77, 8'h02);
        result(8'h10);
        chk("restart_len1", 32'(chain_len), 32'd1);
        issue(2'd1, 2'd0, 8'h00, 8'h04, 8'h10, 8'h04);
        result(8'h20);
        issue(2'd1, 2'd0, 8'h00, 8'h05, 8'h20, 8'h05);
        result(8'h30);
        chk("chain_len3", 32'(chain_len), 32'd3);

        // History reads: [30,20,10] then full, then oldest dropped
        issue(2'd2, 2'd2, 8'hAA, 8'h06, 8'h10, 8'h06);
        chk("hist2_no_err", 32'(sel_err), 32'd0);
        result(8'h40);
        issue(2'd2, 2'd3, 8'hAB, 8'h07, 8'h10, 8'h07);
        result(8'h50);
        issue(2'd2, 2'd3, 8'hAC, 8'h08, 8'h20, 8'h08);
        result(8'h60);
        chk("chain_len6", 32'(chain_len), 32'd6);

        // Reserved code behaves as A and starts a new chain
        issue(2'd3, 2'd0, 8'h5C, 8'h09, 8'h5C, 8'h09);
        result(8'h61);
        chk("rsvd_len1", 32'(chain_len), 32'd1);

        // Empty history entry: falls back to A, sel_err pulses, new chain
        issue(2'd2, 2'd1, 8'h44, 8'h0A, 8'h44, 8'h0A);
        chk("sel_err_pulse", 32'(sel_err), 32'd1);
        result(8'h62);
        chk("sel_err_clears", 32'(sel_err), 32'd0);
        chk("sel_err_len1", 32'(chain_len), 32'd1);
        issue(2'd2, 2'd0, 8'h01, 8'h0B, 8'h62, 8'h0B);
        result(8'h63);

        // clear with a same-cycle op_valid in CHAIN
        clear = 1'b1; op_valid = 1'b1; src_sel = 2'd0; a = 8'hDD;
        tick();
        clear = 1'b0; op_valid = 1'b0;
        chk("clear_no_valid", 32'(opnd_valid), 32'd0);
        chk("clear_first", 32'(first), 32'd1);
        chk("clear_len0", 32'(chain_len), 32'd0);
        chk("clear_opnd_a_hold", 32'(opnd_a), 32'h62);

        // res_valid in IDLE must not touch length or history
        result(8'h7E);
        chk("idle_res_len0", 32'(chain_len), 32'd0);
        chk("idle_res_ready", 32'(op_ready), 32'd1);
        issue(2'd1, 2'd0, 8'h11, 8'h0C, 8'h11, 8'h0C);
        result(8'h12);
        issue(2'd2, 2'd1, 8'h21, 8'h0D, 8'h21, 8'h0D);
        chk("idle_res_not_pushed", 32'(sel_err), 32'd1);
        result(8'h13);
        chk("len_after_err", 32'(chain_len), 32'd1);

        // 16 chained ops: chain_len saturates at 15
        last = 8'h13;
        for (int i = 0; i < 16; i++) begin
            issue(2'd1, 2'd0, 8'h00, 8'(i), last, 8'(i));
            last = 8'h80 + 8'(i);
            result(last);
            chk("chain_len_sat", 32'(chain_len), (i + 2 > 15) ? 32'd15 : 32'(i + 2));
        end

        // res_valid in CHAIN is ignored
        result(8'hEE);
        chk("chain_res_len", 32'(chain_len), 32'd15);
        issue(2'd1, 2'd0, 8'h00, 8'h31, last, 8'h31);

        // Asynchronous reset mid-chain
        #2 rst = 1'b1;
        #1;
        chk("midrst_opnd_a", 32'(opnd_a), 32'h00);
        chk("midrst_opnd_valid", 32'(opnd_valid), 32'd0);
        chk("midrst_len", 32'(chain_len), 32'd0);
        chk("midrst_ready", 32'(op_ready), 32'd1);
        chk("midrst_first", 32'(first), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

`ifdef OPERAND_SWAP_EN
        // Swap exchanges operands after source selection
        issue(2'd0, 2'd0, 8'h01, 8'h02, 8'h01, 8'h02);
        result(8'h40);
        swap = 1'b1;
        issue(2'd1, 2'd0, 8'h00, 8'h05, 8'h05, 8'h40);
        swap = 1'b0;
        result(8'h41);
`endif

        tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
